// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// decoded opcode/funct values, ALU operation codes and next-PC selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
   } state_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_NONE  = 2'b11
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] PC_SRC_INC = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Bundle between the control FSM and the datapath/memory: instruction
// fields and status in, enables and mux selects out.
interface mips_mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             mem_ready;
   logic             mem_req;
   logic             mem_we;
   logic             iord;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             reg_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [2:0]       alu_control;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport ctrl (
      input  opcode, funct, zero, mem_ready,
      output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control,
             illegal, retired
   );

   modport dp (
      output opcode, funct, zero, mem_ready,
      input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control,
             illegal, retired
   );
endinterface

// File: rtl/mips_alu_dec.sv
// ALU operation decoder: fixed add/sub for address and branch work,
// funct-driven for R-type execution.
module mips_alu_dec
   import mips_ctrl_pkg::*;
(
   input  alu_op_e    alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = 3'b000;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            // Unknown funct falls back to add and still retires normally.
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = 3'b000;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute, owns the
// memory handshake, traps unsupported opcodes and counts retirements.
module mips_mc_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic          clk,
   input logic          rst_n,
   mips_mc_ctrl_if.ctrl bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q;
   logic             retire;
   alu_op_e          alu_op;

   mips_alu_dec u_alu_dec (
      .alu_op      (alu_op),
      .funct       (bus.funct),
      .alu_control (bus.alu_control)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign bus.retired = retired_q;

   always_comb begin
      state_d        = state_q;
      retire         = 1'b0;
      alu_op         = ALUOP_NONE;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.iord       = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = PC_SRC_INC;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            bus.mem_req   = 1'b1;
            bus.alu_src_b = 2'b01;
            alu_op        = ALUOP_ADD;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
            if (bus.mem_ready) state_d = DECODE;
         end
         DECODE: begin
            bus.alu_src_b = 2'b11;
            alu_op        = ALUOP_ADD;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default:      state_d = TRAP;
            endcase
         end
         MEMADR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            alu_op        = ALUOP_ADD;
            state_d       = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.mem_req = 1'b1;
            bus.iord    = 1'b1;
            if (bus.mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            retire         = 1'b1;
            state_d        = FETCH;
         end
         MEMWR: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = 1'b1;
            bus.iord    = 1'b1;
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         EXEC: begin
            bus.alu_src_a = 1'b1;
            alu_op        = ALUOP_FUNCT;
            state_d       = ALUWB;
         end
         ALUWB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
            retire        = 1'b1;
            state_d       = FETCH;
         end
         BRANCH: begin
            bus.alu_src_a = 1'b1;
            alu_op        = ALUOP_SUB;
            bus.pc_src    = PC_SRC_BR;
            bus.pc_write  = bus.zero;
            retire        = 1'b1;
            state_d       = FETCH;
         end
         ADDIEX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            alu_op        = ALUOP_ADD;
            state_d       = ADDIWB;
         end
         ADDIWB: begin
            bus.reg_write = 1'b1;
            retire        = 1'b1;
            state_d       = FETCH;
         end
         JUMP: begin
            bus.pc_src   = PC_SRC_JMP;
            bus.pc_write = 1'b1;
            retire       = 1'b1;
            state_d      = FETCH;
         end
         TRAP: begin
            bus.illegal = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle expected control vectors go
// through a scoreboard queue; a 2-bit-counter twin exercises counter wrap.
module tb_mips_mc_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic       illegal;
   } outs_t;

   localparam int B_FETCH = 0, B_DECODE = 1, B_MEMADR = 2, B_MEMRD = 3,
                  B_MEMWB = 4, B_MEMWR = 5, B_EXEC = 6, B_ALUWB = 7,
                  B_BRANCH = 8, B_ADDIEX = 9, B_ADDIWB = 10, B_JUMP = 11,
                  B_TRAP = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   outs_t exp_q[$];

   mips_mc_ctrl_if #(.CNT_W(32)) bus ();
   mips_mc_ctrl_if #(.CNT_W(2))  bus2 ();

   mips_mc_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.ctrl));
   mips_mc_ctrl #(.CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.ctrl));

   assign bus2.opcode    = bus.opcode;
   assign bus2.funct     = bus.funct;
   assign bus2.zero      = bus.zero;
   assign bus2.mem_ready = bus.mem_ready;

   always #5 clk = ~clk;

   function automatic outs_t exp_vec(input int st, input logic rdy,
                                     input logic z, input logic [2:0] alu_e);
      outs_t o = '0;
      case (st)
         B_FETCH:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.alu_control = 3'b010;
                         o.ir_write = rdy; o.pc_write = rdy; end
         B_DECODE: begin o.alu_src_b = 2'b11; o.alu_control = 3'b010; end
         B_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
         B_MEMRD:  begin o.mem_req = 1; o.iord = 1; end
         B_MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
         B_MEMWR:  begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
         B_EXEC:   begin o.alu_src_a = 1; o.alu_control = alu_e; end
         B_ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; end
         B_BRANCH: begin o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_src = 2'b01;
                         o.pc_write = z; end
         B_ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
         B_ADDIWB: begin o.reg_write = 1; end
         B_JUMP:   begin o.pc_src = 2'b10; o.pc_write = 1; end
         B_TRAP:   begin o.illegal = 1; end
         default:  o = '0;
      endcase
      return o;
   endfunction

   function automatic outs_t observed();
      return '{bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
               bus.pc_src, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
               bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.illegal};
   endfunction

   // One clock cycle: drive inputs, queue the expectation, check at negedge.
   task automatic cyc(input int st, input logic rdy, input logic z,
                      input logic [2:0] alu_e, input string tag);
      outs_t got, e;
      bus.mem_ready = rdy;
      bus.zero      = z;
      exp_q.push_back(exp_vec(st, rdy, z, alu_e));
      @(negedge clk);
      got = observed();
      e   = exp_q.pop_front();
      n_cmp++;
      assert (got === e) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ret(input int n, input string tag);
      n_cmp++;
      assert (bus.retired === 32'(n)) else begin
         n_err++;
         $error("FAIL %s: retired observed=%0d expected=%0d", tag, bus.retired, n);
      end
      n_cmp++;
      assert (bus2.retired === 2'(n)) else begin
         n_err++;
         $error("FAIL %s_w2: retired observed=%0d expected=%0d", tag, bus2.retired, n % 4);
      end
   endtask

   logic [5:0] fn_tab[5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
   logic [2:0] al_tab[5] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

   initial begin
      bus.opcode = 6'b000000; bus.funct = 6'b100000;
      bus.zero = 1'b0; bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cyc(B_FETCH, 0, 0, 0, "reset_outs");
      chk_ret(0, "reset_ret");
      rst_n = 1'b1;

      // add, no waits: 4 cycles
      bus.opcode = 6'b000000; bus.funct = 6'b100000;
      cyc(B_FETCH, 1, 0, 0, "add_fetch");
      cyc(B_DECODE, 1, 0, 0, "add_decode");
      cyc(B_EXEC, 1, 0, 3'b010, "add_exec");
      cyc(B_ALUWB, 1, 0, 0, "add_wb");
      $display("add: 4 cycles, retired=%0d", bus.retired);
      chk_ret(1, "add_ret");

      // lw with 2 fetch waits and 1 memrd wait: 8 cycles
      bus.opcode = 6'b100011;
      cyc(B_FETCH, 0, 0, 0, "lw_fetch_w0");
      cyc(B_FETCH, 0, 0, 0, "lw_fetch_w1");
      cyc(B_FETCH, 1, 0, 0, "lw_fetch");
      cyc(B_DECODE, 1, 0, 0, "lw_decode");
      cyc(B_MEMADR, 1, 0, 0, "lw_memadr");
      cyc(B_MEMRD, 0, 0, 0, "lw_memrd_w0");
      cyc(B_MEMRD, 1, 0, 0, "lw_memrd");
      cyc(B_MEMWB, 1, 0, 0, "lw_memwb");
      $display("lw: 8 cycles, retired=%0d", bus.retired);
      chk_ret(2, "lw_ret");

      // beq taken then not taken
      bus.opcode = 6'b000100;
      cyc(B_FETCH, 1, 0, 0, "beq1_fetch");
      cyc(B_DECODE, 1, 0, 0, "beq1_decode");
      cyc(B_BRANCH, 1, 1, 0, "beq1_branch");
      cyc(B_FETCH, 1, 1, 0, "beq0_fetch");
      cyc(B_DECODE, 1, 1, 0, "beq0_decode");
      cyc(B_BRANCH, 1, 0, 0, "beq0_branch");
      $display("beq x2: retired=%0d", bus.retired);
      chk_ret(4, "beq_ret");

      // j then sw (mem_ready high outside memory states is ignored)
      bus.opcode = 6'b000010;
      cyc(B_FETCH, 1, 0, 0, "j_fetch");
      cyc(B_DECODE, 1, 0, 0, "j_decode");
      cyc(B_JUMP, 1, 0, 0, "j_jump");
      bus.opcode = 6'b101011;
      cyc(B_FETCH, 1, 0, 0, "sw_fetch");
      cyc(B_DECODE, 1, 0, 0, "sw_decode");
      cyc(B_MEMADR, 1, 0, 0, "sw_memadr");
      cyc(B_MEMWR, 0, 0, 0, "sw_memwr_w0");
      cyc(B_MEMWR, 1, 0, 0, "sw_memwr");
      $display("j+sw: retired=%0d", bus.retired);
      chk_ret(6, "jsw_ret");

      // remaining R-type functs, including an unsupported one (adds)
      bus.opcode = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         bus.funct = fn_tab[i];
         cyc(B_FETCH, 1, 0, 0, "rt_fetch");
         cyc(B_DECODE, 1, 0, 0, "rt_decode");
         cyc(B_EXEC, 1, 0, al_tab[i], "rt_exec");
         cyc(B_ALUWB, 1, 0, 0, "rt_wb");
         $display("rtype funct=%b: alu=%b retired=%0d", fn_tab[i], al_tab[i], bus.retired);
         chk_ret(7 + i, "rt_ret");
      end

      // addi
      bus.opcode = 6'b001000;
      cyc(B_FETCH, 1, 0, 0, "addi_fetch");
      cyc(B_DECODE, 1, 0, 0, "addi_decode");
      cyc(B_ADDIEX, 1, 0, 0, "addi_ex");
      cyc(B_ADDIWB, 1, 0, 0, "addi_wb");
      $display("addi: retired=%0d", bus.retired);
      chk_ret(12, "addi_ret");

      // reset during MEMRD of lw aborts it
      bus.opcode = 6'b100011;
      cyc(B_FETCH, 1, 0, 0, "lwr_fetch");
      cyc(B_DECODE, 1, 0, 0, "lwr_decode");
      cyc(B_MEMADR, 1, 0, 0, "lwr_memadr");
      cyc(B_MEMRD, 0, 0, 0, "lwr_memrd");
      rst_n = 1'b0;
      #1;
      chk_ret(0, "lwr_ret_in_reset");
      cyc(B_FETCH, 0, 0, 0, "lwr_in_reset");
      rst_n = 1'b1;
      cyc(B_FETCH, 0, 0, 0, "lwr_release");
      $display("lw aborted by reset: retired=%0d", bus.retired);
      chk_ret(0, "lwr_ret");

      // unsupported opcode traps until reset
      bus.opcode = 6'b111111;
      cyc(B_FETCH, 1, 0, 0, "trap_fetch");
      cyc(B_DECODE, 1, 0, 0, "trap_decode");
      cyc(B_TRAP, 1, 0, 0, "trap_enter");
      for (int i = 0; i < 20; i++)
         cyc(B_TRAP, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, "trap_hold");
      $display("trap: illegal=%b retired=%0d", bus.illegal, bus.retired);
      chk_ret(0, "trap_ret");
      rst_n = 1'b0;
      cyc(B_FETCH, 0, 0, 0, "trap_in_reset");
      rst_n = 1'b1;
      bus.opcode = 6'b000010;
      cyc(B_FETCH, 1, 0, 0, "post_trap_fetch");
      cyc(B_DECODE, 1, 0, 0, "post_trap_decode");
      cyc(B_JUMP, 1, 0, 0, "post_trap_jump");
      $display("post-trap j: retired=%0d", bus.retired);
      chk_ret(1, "post_trap_ret");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
